mac_accumulator: RTL and testbench

- Sequential stage directly downstream of the 8x8 combinational `multiply` block. It consumes that block's 16-bit products through a valid/ready handshake.
- Sums LEN consecutive accepted products into a saturating accumulator, then presents the dot-product result with its own valid/ready handshake.
- Gives the multiplier datapath a registered multiply-accumulate (MAC) path for dot-product style use.

---
 rtl/mac_accumulator.sv | 82 ++++++++
 tb/tb_mac_accumulator.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Saturating multiply-accumulate stage: sums LEN accepted products, then holds
// the dot-product result until the downstream handshake completes.
module mac_accumulator #(
  parameter int LEN   = 4,
  parameter int P_W   = 16,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [P_W-1:0]   in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       count
);

  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] value;
  logic             sat, fire, last;

  always_comb begin
    in_ready  = (state == S_ACC) && !clear;
    fire      = in_valid && in_ready;
    last      = (count == 8'(LEN - 1));
    sum       = {1'b0, acc} + {{(ACC_W + 1 - P_W){1'b0}}, in_data};
    sat       = sum[ACC_W];
    value     = sat ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    state_nxt = state;
    case (state)
      S_ACC: if (fire && last) state_nxt = S_OUT;
      S_OUT: if (out_ready)    state_nxt = S_ACC;
      default:                 state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACC;
      acc       <= '0;
      ovf       <= 1'b0;
      count     <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_ACC) begin
        if (clear) begin
          acc   <= '0;
          count <= '0;
          ovf   <= 1'b0;
        end else if (fire) begin
          if (last) begin
            // Final beat: publish result and restart the sum for the next run
            out_data  <= value;
            out_ovf   <= ovf | sat;
            out_valid <= 1'b1;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
          end else begin
            acc   <= value;
            count <= count + 8'd1;
            ovf   <= ovf | sat;
          end
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a 20-bit and a 16-bit accumulator share
// one stimulus stream so saturation can be exercised alongside the defaults.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        clear;
  logic        out_ready;

  logic        in_ready,  in_ready16;
  logic [19:0] out_data;
  logic [15:0] out_data16;
  logic        out_ovf,   out_ovf16;
  logic        out_valid, out_valid16;
  logic [7:0]  count,     count16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.LEN(4), .P_W(16), .ACC_W(20)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .out_data(out_data),
    .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  mac_accumulator #(.LEN(4), .P_W(16), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready16), .clear(clear), .out_data(out_data16),
    .out_ovf(out_ovf16), .out_valid(out_valid16), .out_ready(out_ready),
    .count(count16)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d);
    in_valid = 1'b1;
    in_data  = 16'(d);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);

    // Back-to-back beats 15, 20, 510, 65025
    out_ready = 1'b1;
    beat(15);
    chk("b2b_count1", count, 1);
    beat(20); beat(510);
    chk("b2b_count3", count, 3);
    beat(65025);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_data", out_data, 65570);
    chk("b2b_ovf", out_ovf, 0);
    chk("b2b_count0", count, 0);
    chk("b2b_in_ready_out", in_ready, 0);
    tick();
    chk("b2b_hs_valid", out_valid, 0);
    chk("b2b_hs_in_ready", in_ready, 1);

    // Bubbles between beats, then 5 cycles of backpressure
    out_ready = 1'b0;
    beat(15); tick(); beat(20); tick(); beat(510); tick();
    chk("bub_count3", count, 3);
    beat(65025);
    chk("bp_valid0", out_valid, 1);
    chk("bp_data0", out_data, 65570);
    in_valid = 1'b1; in_data = 16'd7;
    for (int i = 1; i <= 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 65570);
      chk("bp_count", count, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_hs_valid", out_valid, 0);
    chk("bp_hs_in_ready", in_ready, 1);
    chk("bp_hs_count", count, 0);

    // Clear wins over a simultaneous beat
    beat(100); beat(200);
    chk("clr_count2", count, 2);
    in_valid = 1'b1; in_data = 16'd999; clear = 1'b1;
    #1 chk("clr_in_ready", in_ready, 0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_count0", count, 0);
    beat(1); beat(1); beat(1); beat(1);
    chk("clr_valid", out_valid, 1);
    chk("clr_data", out_data, 4);
    chk("clr_ovf", out_ovf, 0);
    tick();

    // Saturation on the 16-bit instance; sticky flag then clears
    beat(65025); beat(65025);
    chk("sat_count2", count16, 2);
    beat(1); beat(1);
    chk("sat16_valid", out_valid16, 1);
    chk("sat16_data", out_data16, 65535);
    chk("sat16_ovf", out_ovf16, 1);
    chk("sat20_data", out_data, 130052);
    chk("sat20_ovf", out_ovf, 0);
    tick();
    beat(1); beat(2); beat(3); beat(4);
    chk("sat16_next_data", out_data16, 10);
    chk("sat16_next_ovf", out_ovf16, 0);
    tick();
    chk("sat16_hs_valid", out_valid16, 0);

    // Reset mid-accumulation and while holding a result
    out_ready = 1'b0;
    beat(3); beat(3); beat(3);
    chk("rst_mid_count3", count, 3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_count", count, 0);
    chk("rst_mid_valid", out_valid, 0);
    beat(3); beat(3); beat(3); beat(3);
    chk("rst_out_pend", out_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_out_valid0", out_valid, 0);
    chk("rst_out_count0", count, 0);
    chk("rst_out_in_ready", in_ready, 1);
    beat(3); beat(3); beat(3); beat(3);
    chk("rst_run_valid", out_valid, 1);
    chk("rst_run_data", out_data, 12);

    // Clear during OUT must not drop the pending result
    clear = 1'b1;
    tick(); tick();
    chk("oclr_valid", out_valid, 1);
    chk("oclr_data", out_data, 12);
    chk("oclr_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("oclr_hs_valid", out_valid, 0);
    chk("oclr_hs_data", out_data, 12);
    chk("oclr_acc_in_ready", in_ready, 0);
    clear = 1'b0;
    #1 chk("oclr_in_ready_rel", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
